// File: rtl/maxnet_engine.sv
`default_nettype none
// ============================================================================
// maxnet_engine: time-multiplexed MaxNet winner-take-all over N activations.
// Rev 1.0
// ============================================================================
module maxnet_engine #(
    parameter int N         = 4,
    parameter int W         = 32,
    parameter int EPS_SHIFT = 2,
    parameter int MAX_ITER  = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [W-1:0]                  in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(N)-1:0]          winner_idx,
    output logic [W-1:0]                  winner_val,
    output logic [$clog2(MAX_ITER+1)-1:0] iter_count,
    output logic                          no_winner,
    output logic                          timeout,
    output logic                          busy
);
    localparam int IDXW = $clog2(N);
    localparam int ITW  = $clog2(MAX_ITER+1);
    localparam int SW   = W + $clog2(N);
    localparam int CW   = $clog2(N+1);

    typedef enum logic [2:0] {
        S_LOAD   = 3'd0,
        S_SUM    = 3'd1,
        S_UPDATE = 3'd2,
        S_CHECK  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   ptr_q, ptr_d;
    logic [W-1:0]      act_q [N];
    logic [W-1:0]      act_d [N];
    logic [W-1:0]      orig_q [N];
    logic [W-1:0]      orig_d [N];
    logic [SW-1:0]     sum_q, sum_d;
    logic [ITW-1:0]    iter_q, iter_d;
    logic [IDXW-1:0]   widx_q, widx_d;
    logic [W-1:0]      wval_q, wval_d;
    logic              nw_q, nw_d;
    logic              to_q, to_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;

    logic [W-1:0]      w_cur;
    logic [SW-1:0]     w_dec;
    logic              w_last;
    logic [ITW-1:0]    w_iter_inc;
    logic [CW-1:0]     w_nz_cnt;
    logic [IDXW-1:0]   w_first_nz;
    logic [IDXW-1:0]   w_max_idx;
    logic [W-1:0]      w_max_val;
    logic              w_found;
    logic [IDXW-1:0]   w_win_idx;

    assign w_cur      = act_q[ptr_q];
    assign w_dec      = (sum_q - SW'(w_cur)) >> EPS_SHIFT;
    assign w_last     = (ptr_q == IDXW'(N-1));
    assign w_iter_inc = iter_q + ITW'(1);

    // Nonzero census and lowest-index argmax, used only in CHECK.
    always_comb begin
        w_nz_cnt   = '0;
        w_first_nz = '0;
        w_found    = 1'b0;
        w_max_idx  = '0;
        w_max_val  = act_q[0];
        for (int i = 0; i < N; i++) begin
            if (act_q[i] != '0) begin
                w_nz_cnt = w_nz_cnt + CW'(1);
                if (!w_found) begin
                    w_first_nz = IDXW'(i);
                    w_found    = 1'b1;
                end
            end
            if (act_q[i] > w_max_val) begin
                w_max_val = act_q[i];
                w_max_idx = IDXW'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        act_d     = act_q;
        orig_d    = orig_q;
        sum_d     = sum_q;
        iter_d    = iter_q;
        widx_d    = widx_q;
        wval_d    = wval_q;
        nw_d      = nw_q;
        to_d      = to_q;
        w_win_idx = '0;
        case (state_q)
            S_LOAD: begin
                if (in_valid && in_ready_q) begin
                    act_d[ptr_q]  = in_data;
                    orig_d[ptr_q] = in_data;
                    if (w_last) begin
                        ptr_d   = '0;
                        sum_d   = '0;
                        iter_d  = '0;
                        nw_d    = 1'b0;
                        to_d    = 1'b0;
                        state_d = S_SUM;
                    end else begin
                        ptr_d = ptr_q + IDXW'(1);
                    end
                end
            end
            S_SUM: begin
                sum_d = sum_q + SW'(w_cur);
                ptr_d = w_last ? '0 : ptr_q + IDXW'(1);
                if (w_last) state_d = S_UPDATE;
            end
            S_UPDATE: begin
                // Sum is frozen for the whole pass, so in-place update is safe.
                act_d[ptr_q] = (SW'(w_cur) > w_dec) ? W'(SW'(w_cur) - w_dec) : '0;
                ptr_d = w_last ? '0 : ptr_q + IDXW'(1);
                if (w_last) state_d = S_CHECK;
            end
            S_CHECK: begin
                iter_d = w_iter_inc;
                sum_d  = '0;
                if (w_nz_cnt == CW'(1)) begin
                    w_win_idx = w_first_nz;
                    state_d   = S_DONE;
                end else if (w_nz_cnt == '0) begin
                    nw_d    = 1'b1;
                    state_d = S_DONE;
                end else if (w_iter_inc == ITW'(MAX_ITER)) begin
                    w_win_idx = w_max_idx;
                    to_d      = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    state_d = S_SUM;
                end
                if (state_d == S_DONE) begin
                    widx_d = w_win_idx;
                    wval_d = orig_q[w_win_idx];
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_LOAD;
            end
            default: state_d = S_LOAD;
        endcase
        in_ready_d  = (state_d == S_LOAD);
        out_valid_d = (state_d == S_DONE);
        busy_d      = (state_d == S_SUM) || (state_d == S_UPDATE) || (state_d == S_CHECK);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_LOAD;
            ptr_q       <= '0;
            for (int i = 0; i < N; i++) begin
                act_q[i]  <= '0;
                orig_q[i] <= '0;
            end
            sum_q       <= '0;
            iter_q      <= '0;
            widx_q      <= '0;
            wval_q      <= '0;
            nw_q        <= 1'b0;
            to_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            act_q       <= act_d;
            orig_q      <= orig_d;
            sum_q       <= sum_d;
            iter_q      <= iter_d;
            widx_q      <= widx_d;
            wval_q      <= wval_d;
            nw_q        <= nw_d;
            to_q        <= to_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign winner_idx = widx_q;
    assign winner_val = wval_q;
    assign iter_count = iter_q;
    assign no_winner  = nw_q;
    assign timeout    = to_q;
    assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_maxnet_engine.sv
`default_nettype none
// ============================================================================
// tb_maxnet_engine: directed and randomized checks against a MaxNet model.
// Rev 1.0
// ============================================================================
module tb_maxnet_engine;
    localparam int N         = 4;
    localparam int W         = 32;
    localparam int EPS_SHIFT = 2;
    localparam int MAX_ITER  = 16;
    localparam int ITER_LAT  = 2*N + 1;

    typedef struct {
        int          idx;
        logic [31:0] val;
        int          iters;
        bit          nw;
        bit          to;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [1:0]  winner_idx;
    logic [31:0] winner_val;
    logic [4:0]  iter_count;
    logic        no_winner;
    logic        timeout;
    logic        busy;

    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    exp_t exp_q[$];
    logic [31:0] snap [0:MAX_ITER][0:N-1];

    maxnet_engine #(.N(N), .W(W), .EPS_SHIFT(EPS_SHIFT), .MAX_ITER(MAX_ITER)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .winner_idx(winner_idx),
        .winner_val(winner_val), .iter_count(iter_count), .no_winner(no_winner),
        .timeout(timeout), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: iterate the inhibition rule on whole vectors at once.
    task automatic model(input logic [31:0] v[N], output exp_t e);
        longint unsigned a[N];
        longint unsigned b[N];
        longint unsigned s, d;
        int c, first, mx;
        bit fin;
        e.idx = 0; e.iters = 0; e.nw = 0; e.to = 0; fin = 0;
        for (int i = 0; i < N; i++) a[i] = v[i];
        for (int it = 1; it <= MAX_ITER && !fin; it++) begin
            s = 0;
            for (int i = 0; i < N; i++) s += a[i];
            for (int i = 0; i < N; i++) begin
                d = (s - a[i]) >> EPS_SHIFT;
                b[i] = (a[i] > d) ? a[i] - d : 0;
            end
            c = 0; first = -1; mx = 0;
            for (int i = 0; i < N; i++) begin
                a[i] = b[i];
                snap[it][i] = a[i][31:0];
                if (a[i] != 0) begin
                    c++;
                    if (first < 0) first = i;
                end
                if (a[i] > a[mx]) mx = i;
            end
            e.iters = it;
            if (c == 1) begin
                e.idx = first; fin = 1;
            end else if (c == 0) begin
                e.nw = 1; fin = 1;
            end else if (it == MAX_ITER) begin
                e.to = 1; e.idx = mx; fin = 1;
            end
        end
        e.val = v[e.idx];
    endtask

    // Compare process: every cycle a result is presented.
    always @(negedge clk) begin
        if (rst && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", out_valid, 0);
            end else begin
                chk("winner_idx", winner_idx, exp_q[0].idx);
                chk("winner_val", winner_val, exp_q[0].val);
                chk("iter_count", iter_count, exp_q[0].iters);
                chk("no_winner", no_winner, exp_q[0].nw);
                chk("timeout", timeout, exp_q[0].to);
                chk("in_ready_in_done", in_ready, 0);
                chk("busy_in_done", busy, 0);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic load_words(input logic [31:0] v[N], input bit gaps);
        bit hs;
        for (int k = 0; k < N; k++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    in_valid = 0; in_data = $urandom;
                    @(posedge clk); #1;
                end
            end
            in_valid = 1; in_data = v[k];
            hs = 0;
            for (int t = 0; t < 50 && !hs; t++) begin
                @(negedge clk); hs = in_ready;
                @(posedge clk); #1;
            end
            if (!hs) chk("load_handshake", in_ready, 1);
        end
        in_valid = 0; in_data = $urandom;
    endtask

    task automatic run_txn(input logic [31:0] v[N], input bit gaps, input int hold,
                           input bit snaps, output exp_t e);
        int h;
        bit seen;
        model(v, e);
        exp_q.push_back(e);
        load_words(v, gaps);
        h = cyc;
        if (snaps) begin
            for (int j = 1; j <= 2; j++) begin
                repeat (ITER_LAT) @(posedge clk); #1;
                for (int i = 0; i < N; i++) chk("act_after_iter", dut.act_q[i], snap[j][i]);
            end
        end
        seen = 0;
        for (int t = 0; t < 1000 && !seen; t++) begin
            @(negedge clk);
            seen = out_valid;
        end
        chk("out_valid_wait", out_valid, 1);
        if (seen) chk("latency", cyc - h, e.iters * ITER_LAT);
        for (int t = 0; t < hold; t++) begin
            @(posedge clk); #1;
            in_valid = 1; in_data = $urandom;
            @(negedge clk);
            chk("out_valid_hold", out_valid, 1);
        end
        @(posedge clk); #1;
        in_valid = 0; out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        @(negedge clk);
        chk("out_valid_after_ack", out_valid, 0);
        chk("in_ready_after_ack", in_ready, 1);
        chk("winner_val_kept", winner_val, e.val);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] v[N];
        exp_t e;
        int h;

        repeat (2) @(posedge clk); #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_winner_val", winner_val, 0);
        chk("rst_iter_count", iter_count, 0);
        rst = 1;
        @(posedge clk); #1;

        v = '{10, 20, 30, 40};
        run_txn(v, 0, 0, 1, e);
        chk("m1_idx", e.idx, 3);   chk("m1_val", e.val, 40);
        chk("m1_iters", e.iters, 4); chk("m1_flags", {e.nw, e.to}, 0);
        chk("m1_it1_a2", snap[1][2], 13); chk("m1_it1_a3", snap[1][3], 25);
        chk("m1_it2_a2", snap[2][2], 7);  chk("m1_it2_a3", snap[2][3], 22);

        v = '{0, 0, 7, 0};
        run_txn(v, 0, 0, 0, e);
        chk("m2_idx", e.idx, 2); chk("m2_val", e.val, 7); chk("m2_iters", e.iters, 1);

        v = '{0, 0, 0, 0};
        run_txn(v, 0, 0, 0, e);
        chk("m3_nw", e.nw, 1); chk("m3_to", e.to, 0); chk("m3_iters", e.iters, 1);

        v = '{5, 5, 5, 5};
        run_txn(v, 0, 0, 0, e);
        chk("m4_to", e.to, 1); chk("m4_iters", e.iters, 16);
        chk("m4_idx", e.idx, 0); chk("m4_val", e.val, 5); chk("m4_stall", snap[3][1], 1);

        v = '{10, 20, 30, 40};
        run_txn(v, 1, 10, 0, e);

        v = '{10, 20, 30, 40};
        load_words(v, 0);
        h = cyc;
        repeat (5) @(posedge clk); #2;
        rst = 0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_busy", busy, 0);
        chk("arst_winner_idx", winner_idx, 0);
        chk("arst_winner_val", winner_val, 0);
        chk("arst_iter_count", iter_count, 0);
        chk("arst_flags", {no_winner, timeout}, 0);
        chk("arst_act3", dut.act_q[3], 0);
        chk("arst_sum", dut.sum_q, 0);
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        run_txn(v, 0, 0, 1, e);

        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < N; i++)
                v[i] = (r % 2 == 0) ? $urandom_range(0, 15) : $urandom;
            run_txn(v, $urandom_range(0, 1), $urandom_range(0, 3), 0, e);
        end

        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
